// File: rtl/led_seq_pkg.sv
// ============================================================================
// led_seq_pkg
// Shared mode, FSM-state and bounce-direction encodings for led_pattern_seq.
// Revision: 1.0
// ============================================================================
`default_nettype none

package led_seq_pkg;

    localparam logic [1:0] MODE_SHL    = 2'b00;
    localparam logic [1:0] MODE_SHR    = 2'b01;
    localparam logic [1:0] MODE_BOUNCE = 2'b10;
    localparam logic [1:0] MODE_BLINK  = 2'b11;

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_RUN  = 1'b1;

    localparam logic [0:0] DIR_LEFT  = 1'b0;
    localparam logic [0:0] DIR_RIGHT = 1'b1;

endpackage

`default_nettype wire

// File: rtl/led_prescaler.sv
// ============================================================================
// led_prescaler
// Step-period prescaler: emits a tick every period+1 enabled cycles.
// Revision: 1.0
// ============================================================================
`default_nettype none

module led_prescaler #(
    parameter int DIV_W = 24
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clear,
    input  logic [DIV_W-1:0] period,
    output logic             tick
);

    logic [DIV_W-1:0] r_count;

    // >= rather than == so that lowering period below the count ticks at once
    assign tick = en && !clear && (r_count >= period);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (clear) begin
            r_count <= '0;
        end else if (en) begin
            if (tick) begin
                r_count <= '0;
            end else begin
                r_count <= r_count + DIV_W'(1);
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/led_pattern_seq.sv
// ============================================================================
// led_pattern_seq
// Rotate / bounce / blink LED pattern sequencer with programmable step period.
// Optional macro LED_PWM_EN adds a 4-bit duty input for brightness control.
// Revision: 1.0
// ============================================================================
`default_nettype none

module led_pattern_seq
    import led_seq_pkg::*;
#(
    parameter int LED_W = 4,
    parameter int DIV_W = 24
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic [DIV_W-1:0] period,
    input  logic [LED_W-1:0] seed,
    input  logic             load,
`ifdef LED_PWM_EN
    input  logic [3:0]       duty,
`endif
    output logic [LED_W-1:0] led_out,
    output logic             step
);

    logic [0:0]       r_state;
    logic [0:0]       w_next_state;
    logic             w_run;
    logic             w_tick;
    logic [LED_W-1:0] r_led;
    logic [LED_W-1:0] w_led_next;
    logic [0:0]       r_dir;
    logic [0:0]       w_dir_next;
    logic             r_step;
    logic [LED_W-1:0] w_rol;
    logic [LED_W-1:0] w_ror;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:  if (en)  w_next_state = S_RUN;
            S_RUN:   if (!en) w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    // Running is decided by the state being entered, so en acts on the same edge
    always_comb begin
        w_run = (w_next_state == S_RUN);
    end

    led_prescaler #(
        .DIV_W (DIV_W)
    ) u_prescaler (
        .clk    (clk),
        .rst    (rst),
        .en     (w_run),
        .clear  (load),
        .period (period),
        .tick   (w_tick)
    );

    assign w_rol = (r_led << 1) | (r_led >> (LED_W - 1));
    assign w_ror = (r_led >> 1) | (r_led << (LED_W - 1));

    always_comb begin
        w_led_next = r_led;
        w_dir_next = r_dir;
        case (mode)
            MODE_SHL:   w_led_next = w_rol;
            MODE_SHR:   w_led_next = w_ror;
            MODE_BOUNCE: begin
                if (LED_W > 1) begin
                    if (r_dir == DIR_LEFT) begin
                        if (r_led[LED_W-1]) begin
                            w_dir_next = DIR_RIGHT;
                            w_led_next = r_led >> 1;
                        end else begin
                            w_led_next = r_led << 1;
                        end
                    end else begin
                        if (r_led[0]) begin
                            w_dir_next = DIR_LEFT;
                            w_led_next = r_led << 1;
                        end else begin
                            w_led_next = r_led >> 1;
                        end
                    end
                end
            end
            MODE_BLINK: w_led_next = ~r_led;
            default:    w_led_next = r_led;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_led  <= LED_W'(1);
            r_dir  <= DIR_LEFT;
            r_step <= 1'b0;
        end else if (load) begin
            r_led  <= (seed == '0) ? LED_W'(1) : seed;
            r_dir  <= DIR_LEFT;
            r_step <= 1'b0;
        end else begin
            r_step <= w_tick;
            if (w_tick) begin
                r_led <= w_led_next;
                r_dir <= w_dir_next;
            end
        end
    end

    assign step = r_step;

`ifdef LED_PWM_EN
    logic [3:0] r_pwm_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pwm_cnt <= 4'd0;
        end else begin
            r_pwm_cnt <= r_pwm_cnt + 4'd1;
        end
    end

    assign led_out = r_led & {LED_W{r_pwm_cnt <= duty}};
`else
    assign led_out = r_led;
`endif

endmodule

`default_nettype wire

// File: tb/tb_led_pattern_seq.sv
// ============================================================================
// tb_led_pattern_seq
// Directed self-checking bench for led_pattern_seq (LED_W=4, DIV_W=24).
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_led_pattern_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic [1:0]  mode;
    logic [23:0] period;
    logic [3:0]  seed;
    logic        load;
    logic [3:0]  led_out;
    logic        step;
`ifdef LED_PWM_EN
    logic [3:0]  duty = 4'd15;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    led_pattern_seq #(
        .LED_W (4),
        .DIV_W (24)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .mode    (mode),
        .period  (period),
        .seed    (seed),
        .load    (load),
`ifdef LED_PWM_EN
        .duty    (duty),
`endif
        .led_out (led_out),
        .step    (step)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one edge, then check led_out and step away from the edge
    task automatic edge_chk(input string tag, input logic [3:0] exp_led, input logic exp_step);
        @(posedge clk);
        #1;
        check({tag, "_led"}, {28'd0, led_out}, {28'd0, exp_led});
        check({tag, "_step"}, {31'd0, step}, {31'd0, exp_step});
    endtask

    // Asynchronous reset pulse placed between edges, checked while asserted
    task automatic rst_pulse(input string tag);
        rst = 1'b1;
        #1;
        check({tag, "_rled"}, {28'd0, led_out}, 32'd1);
        check({tag, "_rstep"}, {31'd0, step}, 32'd0);
        rst = 1'b0;
    endtask

    initial begin
        logic [3:0] t1_led [12] = '{4'h1, 4'h1, 4'h2, 4'h2, 4'h2, 4'h4,
                                    4'h4, 4'h4, 4'h8, 4'h8, 4'h8, 4'h1};
        logic [3:0] t2_led [5]  = '{4'h8, 4'h4, 4'h2, 4'h1, 4'h8};
        logic [3:0] t3_led [7]  = '{4'h2, 4'h4, 4'h8, 4'h4, 4'h2, 4'h1, 4'h2};

        rst = 1'b1; en = 1'b0; mode = 2'b00; period = 24'd0; seed = 4'd0; load = 1'b0;
        #2;
        check("async_rst_led", {28'd0, led_out}, 32'd1);
        check("async_rst_step", {31'd0, step}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // 1: SHL, period 2 -> step every third edge
        en = 1'b1; mode = 2'b00; period = 24'd2;
        for (int k = 0; k < 12; k++)
            edge_chk("t1", t1_led[k], (k % 3) == 2);

        // 2: SHR, period 0
        rst_pulse("t2");
        mode = 2'b01; period = 24'd0;
        for (int k = 0; k < 5; k++)
            edge_chk("t2", t2_led[k], 1'b1);

        // 3: BOUNCE, period 0
        rst_pulse("t3");
        mode = 2'b10;
        for (int k = 0; k < 7; k++)
            edge_chk("t3", t3_led[k], 1'b1);

        // 4: zero seed loads 1; then BLINK from 0101
        mode = 2'b11; load = 1'b1; seed = 4'h0;
        edge_chk("t4_zero", 4'h1, 1'b0);
        seed = 4'h5;
        edge_chk("t4_seed", 4'h5, 1'b0);
        load = 1'b0;
        edge_chk("t4_b0", 4'hA, 1'b1);
        edge_chk("t4_b1", 4'h5, 1'b1);
        edge_chk("t4_b2", 4'hA, 1'b1);

        // 5: en freeze with period 3
        rst_pulse("t5");
        mode = 2'b00; period = 24'd3; en = 1'b1;
        edge_chk("t5_run0", 4'h1, 1'b0);
        edge_chk("t5_run1", 4'h1, 1'b0);
        en = 1'b0;
        for (int k = 0; k < 5; k++)
            edge_chk("t5_idle", 4'h1, 1'b0);
        en = 1'b1;
        edge_chk("t5_re0", 4'h1, 1'b0);
        edge_chk("t5_re1", 4'h2, 1'b1);

        // 6: reset and load both return bounce direction to LEFT
        rst_pulse("t6a");
        mode = 2'b10; period = 24'd0;
        edge_chk("t6_b0", 4'h2, 1'b1);
        edge_chk("t6_b1", 4'h4, 1'b1);
        edge_chk("t6_b2", 4'h8, 1'b1);
        edge_chk("t6_b3", 4'h4, 1'b1);
        rst_pulse("t6b");
        edge_chk("t6_r0", 4'h2, 1'b1);
        edge_chk("t6_r1", 4'h4, 1'b1);
        edge_chk("t6_r2", 4'h8, 1'b1);
        edge_chk("t6_r3", 4'h4, 1'b1);
        load = 1'b1; seed = 4'h4;
        edge_chk("t6_ld", 4'h4, 1'b0);
        load = 1'b0;
        edge_chk("t6_ld1", 4'h8, 1'b1);

        // 7: lowering period below the running count ticks on the next edge
        rst_pulse("t7");
        mode = 2'b00; period = 24'd5;
        edge_chk("t7_c0", 4'h1, 1'b0);
        edge_chk("t7_c1", 4'h1, 1'b0);
        edge_chk("t7_c2", 4'h1, 1'b0);
        period = 24'd1;
        edge_chk("t7_low", 4'h2, 1'b1);
        edge_chk("t7_p0", 4'h2, 1'b0);
        edge_chk("t7_p1", 4'h4, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule

`default_nettype wire

// File: doc/led_pattern_seq.md
Name: led_pattern_seq

Overview:
Parametrised LED pattern sequencer. It is the next generation of the fixed 4-bit "shift left slow" LED block. It generates rotate-left, rotate-right, bounce and blink patterns on LED_W outputs. A programmable prescaler sets the step period, so one block replaces the fixed-speed, fixed-direction variants. It sits between the board clock and the LED pins as a swappable pattern source.

Parameters:
LED_W, 4, number of LED outputs (>=1)
DIV_W, 24, width of the step-period prescaler

Ports:
clk  in  1  system clock; the only clock
rst  in  1  asynchronous, active-high reset
en  in  1  run enable; 0 freezes pattern and prescaler
mode  in  2  00 SHL, 01 SHR, 10 BOUNCE, 11 BLINK
period  in  DIV_W  step period = period+1 clk cycles
seed  in  LED_W  pattern loaded on load
load  in  1  one-cycle pulse: load seed, restart prescaler
led_out  out  LED_W  LED drive, registered
step  out  1  one-cycle pulse, high in the cycle led_out takes a new value

Behaviour:
- Interface: one clock, clk. Reset rst is asynchronous and active-high. All state is cleared immediately on rst=1, including mid-operation.
- Reset values: led_out=1 (LSB only), step=0, prescaler count=0, bounce direction=LEFT, FSM=IDLE.
- FSM has two states:
  - IDLE: entered when en=0. Count and led hold; step=0.
  - RUN: entered when en=1. Count advances.
  - The transition takes effect on the edge where en is sampled.
- Prescaler (RUN only):
  - Tick when count >= period. On a tick, count goes to 0; otherwise count+1.
  - period=0 gives a tick every cycle.
  - Lowering period below the current count gives a tick on the next RUN cycle.
- Tick action: led updates per the mode sampled that cycle, and step=1 in the same cycle the new led_out appears (registered; zero extra latency).
- Mode actions:
  - SHL: rotate left; MSB wraps to LSB.
  - SHR: rotate right; LSB wraps to MSB.
  - BOUNCE, direction LEFT: if led[LED_W-1]=1, set direction RIGHT and shift right by 1; else shift left by 1, zero fill.
  - BOUNCE, direction RIGHT: mirror of LEFT, using led[0].
  - BLINK: led <= ~led.
- Direction register: kept when leaving BOUNCE. Reset to LEFT by rst and by load.
- load:
  - Has priority over tick and en.
  - Next cycle: led=seed, or 1 if seed==0. Count=0, step=0, direction=LEFT.
  - Works in IDLE and RUN.
- Mode change mid-period does not restart the prescaler.
- LED_W=1: SHL/SHR/BOUNCE hold value (step still pulses); BLINK toggles.

Optional Feature:
Macro LED_PWM_EN.
- Defined:
  - Adds input duty (4 bits) and a free-running 4-bit pwm counter, reset 0, that counts every clk regardless of en.
  - led_out = led_reg & {LED_W{pwm_cnt <= duty}}: duty=15 is always on, duty=0 gives 1/16 on-time.
  - step timing is unaffected.
- Undefined: no duty port, no pwm counter; led_out = led_reg.

Decomposition:
- Package led_seq_pkg holds:
  - mode constants MODE_SHL=2'b00, MODE_SHR=2'b01, MODE_BOUNCE=2'b10, MODE_BLINK=2'b11
  - FSM state encodings S_IDLE, S_RUN
  - direction constants DIR_LEFT, DIR_RIGHT
- Sub-module led_prescaler (parameter DIV_W):
  - inputs clk, rst, en, clear, period
  - output tick
  - contains the count register and the >= compare.
- Pattern datapath and FSM stay in led_pattern_seq.

Test Plan:
1. LED_W=4. Assert rst → led_out=0001, step=0 immediately, asynchronously. Release; en=1, SHL, period=2 → step every 3rd cycle; led 0010,0100,1000,0001.
2. SHR, period=0, en=1 from reset → step every cycle; led 1000,0100,0010,0001,1000.
3. BOUNCE, period=0, from 0001 → 0010,0100,1000,0100,0010,0001,0010.
4. load with seed=0 → led=0001, step=0. Then load seed=0101, BLINK, period=0 → 1010,0101,1010.
5. period=3, en=1: drop en after 2 RUN cycles for 5 cycles → no step, led frozen. Re-assert → first step after exactly 2 further en cycles.
6. BOUNCE with direction RIGHT at 0100: pulse rst → 0001, direction LEFT. Next ticks 0010,0100. With LED_PWM_EN and duty=3 → led_out on 4 of every 16 cycles.
